// File: rtl/clint_pkg.sv
// Shared constants and mstatus update helpers for the machine-mode trap sequencer.
package clint_pkg;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    localparam logic [63:0] CAUSE_MTIMER_INT = 64'h8000_0000_0000_0007;
    localparam logic [63:0] CAUSE_ECALL_M    = 64'd11;

    typedef enum logic [1:0] {
        KIND_NONE  = 2'd0,
        KIND_INT   = 2'd1,
        KIND_ECALL = 2'd2,
        KIND_MRET  = 2'd3
    } kind_e;

    function automatic logic [63:0] mstatus_trap(input logic [63:0] s);
        logic [63:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [63:0] mstatus_mret(input logic [63:0] s);
        logic [63:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/clint_if.sv
// Bundle of the commit, CSR and fetch-redirect signals around the trap sequencer.
interface clint_if;

    logic        ex_valid;
    logic [63:0] ex_pc;
    logic        ex_ecall;
    logic        ex_mret;
    logic [63:0] csr_mtvec;
    logic [63:0] csr_mepc;
    logic [63:0] csr_mstatus;
    logic        global_int_en;
    logic        mtime_int_en;
    logic        mtime_int_pend;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic        flush;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    modport master (
        input  ex_valid, ex_pc, ex_ecall, ex_mret,
        input  csr_mtvec, csr_mepc, csr_mstatus,
        input  global_int_en, mtime_int_en, mtime_int_pend,
        output csr_wen, csr_waddr, csr_wdata,
        output flush, stall, redirect_valid, redirect_pc
    );

    modport slave (
        output ex_valid, ex_pc, ex_ecall, ex_mret,
        output csr_mtvec, csr_mepc, csr_mstatus,
        output global_int_en, mtime_int_en, mtime_int_pend,
        input  csr_wen, csr_waddr, csr_wdata,
        input  flush, stall, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/clint.sv
// Machine-mode trap sequencer: flush, write mepc/mcause/mstatus, then redirect fetch.
// Define CLINT_VECTORED_EN to enable vectored mtvec targets for interrupts.
module clint
    import clint_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ex_valid,
    input  logic [63:0] i_ex_pc,
    input  logic        i_ex_ecall,
    input  logic        i_ex_mret,
    input  logic [63:0] i_csr_mtvec,
    input  logic [63:0] i_csr_mepc,
    input  logic [63:0] i_csr_mstatus,
    input  logic        i_global_int_en,
    input  logic        i_mtime_int_en,
    input  logic        i_mtime_int_pend,
    output logic        o_csr_wen,
    output logic [11:0] o_csr_waddr,
    output logic [63:0] o_csr_wdata,
    output logic        o_flush,
    output logic        o_stall,
    output logic        o_redirect_valid,
    output logic [63:0] o_redirect_pc
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WR_MEPC    = 3'd1;
    localparam logic [2:0] S_WR_MCAUSE  = 3'd2;
    localparam logic [2:0] S_WR_MSTATUS = 3'd3;
    localparam logic [2:0] S_JUMP       = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [63:0] epc_q, epc_d;
    logic [63:0] cause_q, cause_d;
    kind_e       kind_q, kind_d;

    logic        idle;
    logic        int_take;
    logic        ecall_take;
    logic        mret_take;
    logic [63:0] trap_base;
    logic [63:0] trap_tgt;

    always_comb begin
        idle       = (state_q == S_IDLE);
        int_take   = i_ex_valid & i_global_int_en
                   & i_mtime_int_en & i_mtime_int_pend;
        ecall_take = i_ex_valid & i_ex_ecall;
        mret_take  = i_ex_valid & i_ex_mret;

        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        kind_d  = kind_q;

        case (state_q)
            S_IDLE: begin
                if (int_take) begin
                    state_d = S_WR_MEPC;
                    epc_d   = i_ex_pc;
                    cause_d = CAUSE_MTIMER_INT;
                    kind_d  = KIND_INT;
                end else if (ecall_take) begin
                    state_d = S_WR_MEPC;
                    epc_d   = i_ex_pc;
                    cause_d = CAUSE_ECALL_M;
                    kind_d  = KIND_ECALL;
                end else if (mret_take) begin
                    state_d = S_WR_MSTATUS;
                    kind_d  = KIND_MRET;
                end
            end
            S_WR_MEPC:    state_d = S_WR_MCAUSE;
            S_WR_MCAUSE:  state_d = S_WR_MSTATUS;
            S_WR_MSTATUS: state_d = S_JUMP;
            S_JUMP:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            kind_q  <= KIND_NONE;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            kind_q  <= kind_d;
        end
    end

    assign trap_base = {i_csr_mtvec[63:2], 2'b00};

`ifdef CLINT_VECTORED_EN
    // Vectored mode offsets interrupts by 4*cause; exceptions use the base.
    always_comb begin
        trap_tgt = trap_base;
        if (i_csr_mtvec[1:0] == 2'b01 && kind_q == KIND_INT)
            trap_tgt = trap_base + {cause_q[61:0], 2'b00};
    end
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^i_csr_mtvec[1:0];
    assign trap_tgt = trap_base;
`endif

    always_comb begin
        // Gated by rst_n so a held reset forces every output low.
        o_flush = rst_n & idle & (int_take | ecall_take | mret_take);
        o_stall = ~idle;

        o_csr_wen        = 1'b0;
        o_csr_waddr      = '0;
        o_csr_wdata      = '0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;

        case (state_q)
            S_WR_MEPC: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = ADDR_MEPC;
                o_csr_wdata = epc_q;
            end
            S_WR_MCAUSE: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = ADDR_MCAUSE;
                o_csr_wdata = cause_q;
            end
            S_WR_MSTATUS: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = ADDR_MSTATUS;
                o_csr_wdata = (kind_q == KIND_MRET)
                            ? mstatus_mret(i_csr_mstatus)
                            : mstatus_trap(i_csr_mstatus);
            end
            S_JUMP: begin
                o_redirect_valid = 1'b1;
                o_redirect_pc    = (kind_q == KIND_MRET)
                                 ? i_csr_mepc : trap_tgt;
            end
            default: ;
        endcase
    end

endmodule
